imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_ram.sv | 25 ++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction memory loader.
// Holds the loader FSM encoding and the instruction word width.
package imem_loader_pkg;

  localparam int IW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction RAM and gates the fetch reset.
// Ports: load_* control, byte_* stream, pc/instr_code fetch, cpu_reset_n.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   pc,
  output logic [IW-1:0] instr_code,
  output logic          cpu_reset_n,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err
);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] wptr;
  logic [1:0]    bcnt;
  logic [AW:0]   len;
  logic [IW-1:0] asm_w;
  logic          run;
  logic          err_q;

  logic          len_ok;
  logic          last;
  logic          start_ok;
  logic          start_bad;
  logic          xfer;
  logic          wr_en;
  logic          in_range;
  logic [IW-1:0] rdata;

  assign len_ok = (load_len != '0) &&
                  (load_len <= (AW+1)'(DEPTH));

  assign last = ({1'b0, wptr} + (AW+1)'(1)) == len;

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    xfer      = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          if (len_ok) begin
            start_ok = 1'b1;
            state_n  = RECV;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RECV: begin
        xfer = byte_valid;
        if (byte_valid && bcnt == 2'd3)
          state_n = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_n = last ? DONE : RECV;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Fetch stays in reset from a successful start until DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      bcnt  <= '0;
      len   <= '0;
      asm_w <= '0;
      run   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        wptr <= '0;
        bcnt <= '0;
        len  <= load_len;
        run  <= 1'b0;
      end
      if (xfer) begin
        asm_w[{bcnt, 3'b000} +: 8] <= byte_data;
        bcnt <= bcnt + 2'd1;
      end
      if (wr_en) wptr <= wptr + 1'b1;
      if (state == DONE) run <= 1'b1;
    end
  end

  imem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr),
    .wdata(asm_w),
    .raddr(pc[AW+1:2]),
    .rdata(rdata)
  );

  assign in_range = (pc[1:0] == 2'b00) &&
                    (pc < 32'(4 * DEPTH));

  assign instr_code  = in_range ? rdata : '0;
  assign byte_ready  = (state == RECV);
  assign load_busy   = (state == RECV) ||
                       (state == WRITE);
  assign load_done   = (state == DONE);
  assign load_err    = err_q;
  assign cpu_reset_n = run;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads and reads.
// Stimulus queues expectations; a monitor pops and compares.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   pc;
  logic [31:0]   instr_code;
  logic          cpu_reset_n;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  imem_loader #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .pc         (pc),
    .instr_code (instr_code),
    .cpu_reset_n(cpu_reset_n),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } probe_t;

  typedef struct {
    string      name;
    logic [1:0] kind;
    int         cyc;
  } evt_t;

  probe_t pq[$];
  evt_t   eq[$];
  logic   rd_req;
  int     cyc;
  int     checks;
  int     fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 2 time units after the falling edge.
  always @(negedge clk) begin
    probe_t      p;
    evt_t        e;
    logic [31:0] act;
    logic [1:0]  k;
    #2;
    if (rd_req && pq.size() > 0) begin
      p = pq.pop_front();
      if (p.sel == 0) act = instr_code;
      else act = {27'b0, cpu_reset_n, byte_ready,
                  load_busy, load_done, load_err};
      checks++;
      if (act !== p.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h",
                 p.name, act, p.exp);
      end
    end
    if (load_done === 1'b1 || load_err === 1'b1) begin
      k = {load_err, load_done};
      checks++;
      if (eq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got %b at %0d",
                 k, cyc);
      end else begin
        e = eq.pop_front();
        if (k !== e.kind ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          fails++;
          $display("FAIL %s: got %b@%0d expected %b@%0d",
                   e.name, k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic probe(input string n, input int sel,
                       input logic [31:0] e);
    pq.push_back('{n, sel, e});
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic rd(input string n, input logic [31:0] a,
                    input logic [31:0] e);
    pc = a;
    probe(n, 0, e);
  endtask

  task automatic status(input string n, input logic [4:0] v);
    probe(n, 1, {27'b0, v});
  endtask

  task automatic start(input logic [AW:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n          = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      fails++;
      $display("FAIL byte_timeout: got ready=%b expected 1",
               byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got done=%b expected 1",
               load_done);
    end
    @(negedge clk);
  endtask

  task automatic bad_start(input string n,
                           input logic [AW:0] len);
    eq.push_back('{n, 2'b10, cyc + 1});
    start(len);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    checks     = 0;
    fails      = 0;
    rd_req     = 1'b0;
    reset      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    pc         = '0;
    repeat (2) @(negedge clk);
    status("reset_state", 5'b00000);
    reset = 1'b1;
    @(negedge clk);
    status("post_reset", 5'b00000);

    start(7'd2);
    status("recv_status", 5'b01100);
    t0 = cyc;
    eq.push_back('{"done_latency", 2'b01, t0 + 10});
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done();
    status("run_after_load", 5'b10000);
    rd("rd_w0", 32'd0, 32'h0000_0013);
    rd("rd_w1", 32'd4, 32'h0010_0093);

    bad_start("err_len0", 7'd0);
    status("idle_after_err0", 5'b10000);
    bad_start("err_len65", 7'(DEPTH + 1));
    status("idle_after_err65", 5'b10000);

    start(7'd1);
    status("recv_status2", 5'b01100);
    eq.push_back('{"done_toggle", 2'b01, -1});
    send_word(32'hDEAD_BEEF, 1);
    wait_done();
    rd("rd_toggle", 32'd0, 32'hDEAD_BEEF);
    rd("rd_keep_w1", 32'd4, 32'h0010_0093);

    start(7'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b0;
    status("midload_reset", 5'b00000);
    reset = 1'b1;
    @(negedge clk);
    status("after_midload_reset", 5'b00000);
    bad_start("err_in_reset", 7'd0);
    status("err_keeps_reset", 5'b00000);
    start(7'd1);
    eq.push_back('{"done_reload", 2'b01, -1});
    send_word(32'h1234_5678, 0);
    wait_done();
    rd("rd_reload", 32'd0, 32'h1234_5678);
    status("run_after_reload", 5'b10000);

    rd("rd_misaligned", 32'd2, 32'h0);
    rd("rd_out_of_range", 32'(4 * DEPTH), 32'h0);
    rd("rd_top_addr", 32'hFFFF_FFFC, 32'h0);

    start(7'd2);
    t0 = cyc;
    eq.push_back('{"done_ignore", 2'b01, t0 + 10});
    send_byte(8'hD4);
    send_byte(8'hC3);
    load_start = 1'b1;
    load_len   = 7'd1;
    send_byte(8'hB2);
    load_start = 1'b0;
    send_byte(8'hA1);
    send_word(32'h1122_3344, 0);
    wait_done();
    rd("rd_ignore_w0", 32'd0, 32'hA1B2_C3D4);
    rd("rd_ignore_w1", 32'd4, 32'h1122_3344);

    repeat (3) @(negedge clk);
    checks++;
    if (eq.size() != 0) begin
      fails++;
      $display("FAIL missing_pulse: got %0d left expected 0",
               eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
